proj_gfm_collector: RTL

// - Downstream neighbour of proj_extender. Collects the per-cycle one-hot fragment parts (out_gfm)

---
 rtl/proj_gfm_collector_pkg.sv | 17 +
 rtl/proj_gfm_collector_if.sv | 23 ++
 rtl/proj_gfm_collector_fifo.sv | 51 +++++
 rtl/proj_gfm_collector.sv | 81 ++++++++
 4 files changed

// File: rtl/proj_gfm_collector_pkg.sv
// proj_gfm_collector_pkg: shared sizes, FIFO entry type and assembly state type for the GFM collector
package proj_gfm_collector_pkg;
    localparam int FRAG_PART_ONE_HOT          = 32;
    localparam int FRAG_PARTS_COUNT           = 4;
    localparam int SIGNED_INDICE_LEN          = 11;
    localparam int GFM_COLLECTOR_FIFO_DEPTH   = 4;
    localparam int COLLECTOR_FRAG_LEN_ONE_HOT = FRAG_PARTS_COUNT * FRAG_PART_ONE_HOT;
    localparam int PART_CNT_W                 = $clog2(FRAG_PARTS_COUNT);
    localparam int LEVEL_W                    = $clog2(GFM_COLLECTOR_FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [SIGNED_INDICE_LEN-1:0]          idx;
        logic [COLLECTOR_FRAG_LEN_ONE_HOT-1:0] frag;
    } gfm_entry_t;

    typedef enum logic {COL_IDLE, COL_FILL} col_state_t;
endpackage

// File: rtl/proj_gfm_collector_if.sv
// proj_gfm_collector_if: extender-side fragment parts in, assembled fragments out over valid/ready
interface proj_gfm_collector_if;
    import proj_gfm_collector_pkg::*;
    logic                                  in_start;
    logic                                  in_part_valid;
    logic [FRAG_PART_ONE_HOT-1:0]          in_gfm_part;
    logic [SIGNED_INDICE_LEN-1:0]          in_index;
    logic                                  in_ready;
    logic                                  out_valid;
    logic [COLLECTOR_FRAG_LEN_ONE_HOT-1:0] out_frag;
    logic [SIGNED_INDICE_LEN-1:0]          out_frag_index;
    logic                                  out_overflow;
    logic [LEVEL_W-1:0]                    out_level;

    modport master (
        output in_start, in_part_valid, in_gfm_part, in_index, in_ready,
        input  out_valid, out_frag, out_frag_index, out_overflow, out_level
    );
    modport slave (
        input  in_start, in_part_valid, in_gfm_part, in_index, in_ready,
        output out_valid, out_frag, out_frag_index, out_overflow, out_level
    );
endinterface

// File: rtl/proj_gfm_collector_fifo.sv
// proj_gfm_collector_fifo: registered FIFO of fragment entries; a push into a full FIFO succeeds only with a same-cycle pop
module proj_gfm_collector_fifo
    import proj_gfm_collector_pkg::*;
#(
    parameter int DEPTH = GFM_COLLECTOR_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  gfm_entry_t             din,
    output gfm_entry_t             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    gfm_entry_t   mem_q [DEPTH];
    gfm_entry_t   mem_d [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         do_wr, do_rd;

    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level = wr_q - rd_q;
    assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || do_rd);

    // next storage and pointers; the extra pointer bit separates full from empty
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q + (AW+1)'(do_wr);
        rd_d  = rd_q + (AW+1)'(do_rd);
        if (do_wr) mem_d[wr_q[AW-1:0]] = din;
    end

    // storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/proj_gfm_collector.sv
// proj_gfm_collector: assembles per-cycle one-hot parts into indexed fragments and queues them for downstream
module proj_gfm_collector
    import proj_gfm_collector_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    proj_gfm_collector_if.slave bus
);
    col_state_t                            state_q, state_d, state_eff;
    logic [PART_CNT_W-1:0]                 cnt_q, cnt_d, cnt_eff;
    logic [COLLECTOR_FRAG_LEN_ONE_HOT-1:0] asm_q, asm_d;
    logic [SIGNED_INDICE_LEN-1:0]          idx_q, idx_d;
    logic                                  ovf_q, ovf_d;
    logic                                  push, pop, full, empty;
    gfm_entry_t                            head;

    assign state_eff = bus.in_start ? COL_IDLE : state_q;
    assign cnt_eff   = bus.in_start ? '0 : cnt_q;
    assign pop       = !empty && bus.in_ready;

    // assembly FSM: slot 0 captures the index, the last slot pushes the finished fragment
    always_comb begin
        state_d = state_eff;
        cnt_d   = cnt_eff;
        asm_d   = bus.in_start ? '0 : asm_q;
        idx_d   = idx_q;
        push    = 1'b0;
        if (bus.in_part_valid) begin
            if (state_eff == COL_IDLE) begin
                state_d = COL_FILL;
                cnt_d   = PART_CNT_W'(1);
                idx_d   = bus.in_index;
                asm_d   = COLLECTOR_FRAG_LEN_ONE_HOT'(bus.in_gfm_part);
            end else begin
                asm_d[int'(cnt_eff)*FRAG_PART_ONE_HOT +: FRAG_PART_ONE_HOT] = bus.in_gfm_part;
                if (cnt_eff == PART_CNT_W'(FRAG_PARTS_COUNT-1)) begin
                    push    = 1'b1;
                    state_d = COL_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_eff + 1'b1;
                end
            end
        end
        ovf_d = ovf_q | (push & full & ~pop);
    end

    // assembly state, part counter, partial fragment and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COL_IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    proj_gfm_collector_fifo #(.DEPTH(GFM_COLLECTOR_FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({idx_d, asm_d}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (bus.out_level)
    );

    assign bus.out_valid      = !empty;
    assign bus.out_frag       = head.frag;
    assign bus.out_frag_index = head.idx;
    assign bus.out_overflow   = ovf_q;
endmodule
